uart_cmd_framer: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 78 +++++++
 rtl/uart_frame_ser.sv | 123 ++++++++++++
 rtl/uart_cmd_framer.sv | 139 +++++++++++++
 tb/tb_uart_cmd_framer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types, opcodes and helpers for the UART command framer and its
// byte serializer.
package uart_cmd_pkg;

  localparam int         BYTE_W       = 8;
  localparam logic [5:0] MIN_PRESCALE = 6'd4;

  localparam logic [BYTE_W-1:0] WR_OP   = 8'hAA;
  localparam logic [BYTE_W-1:0] RD_OP   = 8'hBB;
  localparam logic [BYTE_W-1:0] ALU_OP  = 8'hCC;
  localparam logic [BYTE_W-1:0] ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CMD_WR      = 2'd0,
    CMD_RD      = 2'd1,
    CMD_ALU_OP  = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_t;

  // Byte-level phases; the LOAD decision is folded into the START entry.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } ser_state_t;

  // Command-level phases; DRAIN is the idle-line period after an abort.
  typedef enum logic [1:0] {
    CS_IDLE,
    CS_RUN,
    CS_DRAIN
  } cmd_state_t;

  function automatic logic [2:0] frame_count(input cmd_type_t t);
    case (t)
      CMD_WR:     return 3'd3;
      CMD_ALU_OP: return 3'd4;
      default:    return 3'd2;
    endcase
  endfunction

  function automatic logic [5:0] clamp_prescale(input logic [5:0] p);
    return (p < MIN_PRESCALE) ? MIN_PRESCALE : p;
  endfunction

  function automatic logic [BYTE_W-1:0] select_byte(
    input cmd_type_t         t,
    input logic [1:0]        idx,
    input logic [BYTE_W-1:0] addr,
    input logic [BYTE_W-1:0] d0,
    input logic [BYTE_W-1:0] d1,
    input logic [BYTE_W-1:0] fun
  );
    case (t)
      CMD_WR: begin
        case (idx)
          2'd0:    return WR_OP;
          2'd1:    return addr;
          default: return d0;
        endcase
      end
      CMD_RD:     return (idx == 2'd0) ? RD_OP : addr;
      CMD_ALU_OP: begin
        case (idx)
          2'd0:    return ALU_OP;
          2'd1:    return d0;
          2'd2:    return d1;
          default: return fun;
        endcase
      end
      default:    return (idx == 2'd0) ? ALU_NOP : fun;
    endcase
  endfunction

endpackage

// File: rtl/uart_frame_ser.sv
// One-byte UART frame serializer: start, 8 data bits LSB first, optional
// parity, stop, then GAP_BITS idle bit times. GAP_BITS must be 1..8.
module uart_frame_ser
  import uart_cmd_pkg::*;
#(
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              more,
  input  logic              abort,
  input  logic [BYTE_W-1:0] data,
  input  logic              par_en,
  input  logic              par_typ,
  input  logic [5:0]        prescale,
  output logic              line,
  output logic              frame_done,
  output logic              done
);

  ser_state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic       line_q, line_d;
  logic       bit_end;
  logic       parity;

  assign bit_end = (cnt_q == prescale - 6'd1);
  assign parity  = (^data) ^ par_typ;

  // NOTE: every signal written here is defaulted first, so no path leaves a
  // value held and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    frame_done = 1'b0;
    done       = 1'b0;
    line_d     = 1'b1;

    if (state_q != ST_IDLE) cnt_d = bit_end ? 6'd0 : cnt_q + 6'd1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_START;
          cnt_d   = 6'd0;
          idx_d   = 3'd0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = par_en ? ST_PARITY : ST_STOP;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP: begin
        if (bit_end) begin
          frame_done = 1'b1;
          state_d    = ST_GAP;
          idx_d      = 3'd0;
        end
      end
      ST_GAP: begin
        if (bit_end) begin
          if (idx_q == 3'(GAP_BITS - 1)) begin
            done    = 1'b1;
            state_d = more ? ST_START : ST_IDLE;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort restarts a full idle gap from wherever the frame was.
    if (abort) begin
      state_d = ST_GAP;
      cnt_d   = 6'd0;
      idx_d   = 3'd0;
    end

    // Line is computed from the next state so the pin comes straight off a flop.
    case (state_d)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = data[idx_d];
      ST_PARITY: line_d = parity;
      default:   line_d = 1'b1;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      idx_q   <= 3'd0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/uart_cmd_framer.sv
// Host-side command framer driving the DUT's RX_IN line. Define CMD_ABORT_EN
// to add the ABORT input and ABORTED pulse.
module uart_cmd_framer
  import uart_cmd_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 4,
  parameter int GAP_BITS = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_TYPE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [WIDTH-1:0]  CMD_DATA0,
  input  logic [WIDTH-1:0]  CMD_DATA1,
  input  logic [3:0]        CMD_FUN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic [5:0]        PRESCALE,
  output logic              TX_LINE,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              CMD_DONE
`ifdef CMD_ABORT_EN
  ,
  input  logic              ABORT,
  output logic              ABORTED
`endif
);

  cmd_state_t        state_q, state_d;
  cmd_type_t         type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  data0_q, data1_q;
  logic [3:0]        fun_q;
  logic              par_en_q, par_typ_q;
  logic [5:0]        presc_q;
  logic [1:0]        frame_idx_q;

  logic              capture, last_frame, more, abort_req;
  logic              ser_done, ser_frame_done, ser_line;
  logic [BYTE_W-1:0] cur_byte;

  assign capture    = (state_q == CS_IDLE) && CMD_VALID;
  assign last_frame = ({1'b0, frame_idx_q} == frame_count(type_q) - 3'd1);
  assign more       = (state_q == CS_RUN) && !last_frame;
  assign cur_byte   = select_byte(type_q, frame_idx_q, BYTE_W'(addr_q),
                                  data0_q, data1_q, {4'h0, fun_q});

`ifdef CMD_ABORT_EN
  logic aborted_q;

  assign abort_req = ABORT && (state_q == CS_RUN);

  always_ff @(posedge CLK) begin
    if (RST) aborted_q <= 1'b0;
    else     aborted_q <= abort_req;
  end

  assign ABORTED = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    CMD_READY = 1'b0;
    CMD_DONE  = 1'b0;
    case (state_q)
      CS_IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) state_d = CS_RUN;
      end
      CS_RUN: begin
        if (abort_req) begin
          state_d = CS_DRAIN;
        end else if (ser_done && last_frame) begin
          state_d  = CS_IDLE;
          CMD_DONE = 1'b1;
        end
      end
      CS_DRAIN: if (ser_done) state_d = CS_IDLE;
      default:  state_d = CS_IDLE;
    endcase
  end

  assign BUSY = !CMD_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= CS_IDLE;
      frame_idx_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (capture)
        frame_idx_q <= 2'd0;
      else if (state_q == CS_RUN && ser_done && !last_frame && !abort_req)
        frame_idx_q <= frame_idx_q + 2'd1;
    end
  end

  // NOTE: the command payload is left out of reset on purpose; it is only read
  // after a capture has loaded it, so a reset would buy nothing.
  always_ff @(posedge CLK) begin
    if (capture) begin
      type_q    <= cmd_type_t'(CMD_TYPE);
      addr_q    <= CMD_ADDR;
      data0_q   <= CMD_DATA0;
      data1_q   <= CMD_DATA1;
      fun_q     <= CMD_FUN;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      presc_q   <= clamp_prescale(PRESCALE);
    end
  end

  uart_frame_ser #(
    .GAP_BITS(GAP_BITS)
  ) u_ser (
    .clk       (CLK),
    .rst       (RST),
    .start     (capture),
    .more      (more),
    .abort     (abort_req),
    .data      (cur_byte),
    .par_en    (par_en_q),
    .par_typ   (par_typ_q),
    .prescale  (presc_q),
    .line      (ser_line),
    .frame_done(ser_frame_done),
    .done      (ser_done)
  );

  assign TX_LINE    = ser_line;
  assign FRAME_DONE = ser_frame_done;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed bench for uart_cmd_framer: a vector table of commands with
// hand-computed frame bytes, parity bits and timing, plus reset/abort sequences.
module tb_uart_cmd_framer;

  localparam int GAP_BITS = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic [1:0] CMD_TYPE = 2'd0;
  logic [3:0] CMD_ADDR = 4'h0;
  logic [7:0] CMD_DATA0 = 8'h00;
  logic [7:0] CMD_DATA1 = 8'h00;
  logic [3:0] CMD_FUN = 4'h0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] PRESCALE = 6'd8;
  logic       CMD_READY, TX_LINE, BUSY, FRAME_DONE, CMD_DONE;
`ifdef CMD_ABORT_EN
  logic       ABORT = 1'b0;
  logic       ABORTED;
`endif

  uart_cmd_framer #(
    .WIDTH(8),
    .ADDR_W(4),
    .GAP_BITS(GAP_BITS)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_TYPE  (CMD_TYPE),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_DATA0 (CMD_DATA0),
    .CMD_DATA1 (CMD_DATA1),
    .CMD_FUN   (CMD_FUN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .PRESCALE  (PRESCALE),
    .TX_LINE   (TX_LINE),
    .BUSY      (BUSY),
    .FRAME_DONE(FRAME_DONE),
    .CMD_DONE  (CMD_DONE)
`ifdef CMD_ABORT_EN
    ,
    .ABORT     (ABORT),
    .ABORTED   (ABORTED)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]      typ;
    logic [3:0]      addr;
    logic [7:0]      d0;
    logic [7:0]      d1;
    logic [3:0]      fun;
    logic            par_en;
    logic            par_typ;
    logic [5:0]      presc;
    logic            disturb;
    logic [6:0]      p_eff;
    logic [2:0]      nfr;
    logic [3:0][7:0] bytes;
    logic [3:0]      pbits;
    logic [11:0]     cycles;
  } vec_t;

  vec_t vecs [7];
  int   n_checks = 0;
  int   n_fail = 0;
  logic line_buf [4096];
  int   fd_pos [8];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic issue(input logic [1:0] typ, input logic [3:0] addr, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [3:0] fun, input logic par_en,
                       input logic par_typ, input logic [5:0] presc);
    int w;
    w = 0;
    while (!CMD_READY && w < 50) begin
      @(negedge CLK);
      w++;
    end
    CMD_TYPE = typ; CMD_ADDR = addr; CMD_DATA0 = d0; CMD_DATA1 = d1; CMD_FUN = fun;
    PAR_EN = par_en; PAR_TYP = par_typ; PRESCALE = presc;
    CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  // Issues one table command and records the line from cycle 1 (first cycle
  // after the handshake edge) up to one cycle past the expected CMD_DONE.
  task automatic run_vec(input int id, input vec_t v);
    int   flen, p, mism, fd_cnt, cd_cnt, cd_at, ready_bad, busy_bad, b;
    logic expb;
    p    = int'(v.p_eff);
    flen = (10 + int'(v.par_en) + GAP_BITS) * p;
    check($sformatf("v%0d ready before issue", id), CMD_READY, 1);
    issue(v.typ, v.addr, v.d0, v.d1, v.fun, v.par_en, v.par_typ, v.presc);
    fd_cnt = 0; cd_cnt = 0; cd_at = 0; ready_bad = 0; busy_bad = 0;
    for (int n = 1; n <= int'(v.cycles) + 1; n++) begin
      if (n <= int'(v.cycles)) begin
        line_buf[n-1] = TX_LINE;
        if (CMD_READY) ready_bad++;
      end
      if (BUSY !== !CMD_READY) busy_bad++;
      if (FRAME_DONE) begin
        if (fd_cnt < 8) fd_pos[fd_cnt] = n;
        fd_cnt++;
      end
      if (CMD_DONE) begin
        cd_cnt++;
        cd_at = n;
      end
      if (v.disturb && n == 20) begin
        PRESCALE = ~v.presc; PAR_EN = ~v.par_en; PAR_TYP = ~v.par_typ;
        CMD_DATA0 = ~v.d0; CMD_ADDR = ~v.addr; CMD_FUN = ~v.fun; CMD_TYPE = v.typ ^ 2'd1;
        CMD_VALID = 1'b1;
      end
      if (n == 21) CMD_VALID = 1'b0;
      if (n <= int'(v.cycles)) @(negedge CLK);
    end
    check($sformatf("v%0d ready after done", id), CMD_READY, 1);
    check($sformatf("v%0d line idle after done", id), TX_LINE, 1);
    for (int f = 0; f < int'(v.nfr); f++) begin
      mism = 0;
      for (int c = 0; c < flen; c++) begin
        b = c / p;
        if (b == 0)                   expb = 1'b0;
        else if (b <= 8)              expb = v.bytes[f][b-1];
        else if (v.par_en && b == 9)  expb = v.pbits[f];
        else                          expb = 1'b1;
        if (line_buf[f*flen + c] !== expb) mism++;
      end
      check($sformatf("v%0d frame%0d waveform mismatched cycles", id, f), mism, 0);
    end
    check($sformatf("v%0d cmd_done pulses", id), cd_cnt, 1);
    check($sformatf("v%0d cmd_done cycle", id), cd_at, v.cycles);
    check($sformatf("v%0d frame_done pulses", id), fd_cnt, v.nfr);
    mism = 0;
    for (int f = 0; f < int'(v.nfr) && f < fd_cnt && f < 8; f++)
      if (fd_pos[f] != f*flen + (10 + int'(v.par_en)) * p) mism++;
    check($sformatf("v%0d frame_done misplaced pulses", id), mism, 0);
    check($sformatf("v%0d ready high while busy", id), ready_bad, 0);
    check($sformatf("v%0d busy not inverse of ready", id), busy_bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt, pulse_cnt;

    vecs[0] = '{typ:2'd0, addr:4'h2, d0:8'h81, d1:8'h00, fun:4'h0, par_en:1'b1, par_typ:1'b0,
                presc:6'd8, disturb:1'b0, p_eff:7'd8, nfr:3'd3,
                bytes:{8'h00, 8'h81, 8'h02, 8'hAA}, pbits:4'b0010, cycles:12'd312};
    vecs[1] = '{typ:2'd1, addr:4'h5, d0:8'h00, d1:8'h00, fun:4'h0, par_en:1'b0, par_typ:1'b0,
                presc:6'd16, disturb:1'b0, p_eff:7'd16, nfr:3'd2,
                bytes:{8'h00, 8'h00, 8'h05, 8'hBB}, pbits:4'b0000, cycles:12'd384};
    vecs[2] = '{typ:2'd2, addr:4'h0, d0:8'h0F, d1:8'h03, fun:4'h1, par_en:1'b1, par_typ:1'b1,
                presc:6'd32, disturb:1'b0, p_eff:7'd32, nfr:3'd4,
                bytes:{8'h01, 8'h03, 8'h0F, 8'hCC}, pbits:4'b0111, cycles:12'd1664};
    vecs[3] = '{typ:2'd3, addr:4'h0, d0:8'h00, d1:8'h00, fun:4'hA, par_en:1'b0, par_typ:1'b0,
                presc:6'd2, disturb:1'b0, p_eff:7'd4, nfr:3'd2,
                bytes:{8'h00, 8'h00, 8'h0A, 8'hDD}, pbits:4'b0000, cycles:12'd96};
    vecs[4] = '{typ:2'd0, addr:4'hF, d0:8'h00, d1:8'h00, fun:4'h0, par_en:1'b1, par_typ:1'b1,
                presc:6'd0, disturb:1'b1, p_eff:7'd4, nfr:3'd3,
                bytes:{8'h00, 8'h00, 8'h0F, 8'hAA}, pbits:4'b0111, cycles:12'd156};
    vecs[5] = '{typ:2'd1, addr:4'h0, d0:8'h00, d1:8'h00, fun:4'h0, par_en:1'b1, par_typ:1'b0,
                presc:6'd63, disturb:1'b1, p_eff:7'd63, nfr:3'd2,
                bytes:{8'h00, 8'h00, 8'h00, 8'hBB}, pbits:4'b0000, cycles:12'd1638};
    vecs[6] = '{typ:2'd3, addr:4'h0, d0:8'h00, d1:8'h00, fun:4'hF, par_en:1'b1, par_typ:1'b0,
                presc:6'd5, disturb:1'b0, p_eff:7'd5, nfr:3'd2,
                bytes:{8'h00, 8'h00, 8'h0F, 8'hDD}, pbits:4'b0000, cycles:12'd130};

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset tx_line", TX_LINE, 1);
    check("reset cmd_ready", CMD_READY, 1);
    check("reset busy", BUSY, 0);
    check("reset frame_done", FRAME_DONE, 0);
    check("reset cmd_done", CMD_DONE, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle line after reset release", TX_LINE, 1);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset during data bit 3 of frame 2 of a WR (frame 2 byte is addr 0x00).
    issue(2'd0, 4'h0, 8'h55, 8'h00, 4'h0, 1'b0, 1'b0, 6'd8);
    for (int n = 1; n < 131; n++) @(negedge CLK);
    check("rst seq line low in frame2 bit3", TX_LINE, 0);
    RST = 1'b1;
    @(negedge CLK);
    check("rst seq tx_line", TX_LINE, 1);
    check("rst seq cmd_ready", CMD_READY, 1);
    check("rst seq busy", BUSY, 0);
    RST = 1'b0;
    low_cnt = 0; pulse_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      if (!TX_LINE) low_cnt++;
      if (CMD_DONE || FRAME_DONE) pulse_cnt++;
      @(negedge CLK);
    end
    check("rst seq line low after reset", low_cnt, 0);
    check("rst seq done pulses after reset", pulse_cnt, 0);
    run_vec(99, vecs[3]);

`ifdef CMD_ABORT_EN
    begin
      int ab_cnt, ab_at, cd_cnt, ready_at;
      ab_cnt = 0; ab_at = 0; cd_cnt = 0; ready_at = 0; low_cnt = 0;
      issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h3, 1'b0, 1'b0, 6'd8);
      for (int n = 1; n <= 60; n++) begin
        if (n == 3) check("abort seq line low in start", TX_LINE, 0);
        if (ABORTED) begin
          ab_cnt++;
          ab_at = n;
        end
        if (n >= 4 && !TX_LINE) low_cnt++;
        if (CMD_DONE) cd_cnt++;
        if (CMD_READY && ready_at == 0) ready_at = n;
        if (n == 3) ABORT = 1'b1;
        if (n == 4) ABORT = 1'b0;
        @(negedge CLK);
      end
      check("abort seq aborted pulses", ab_cnt, 1);
      check("abort seq aborted cycle", ab_at, 4);
      check("abort seq line low after abort", low_cnt, 0);
      check("abort seq ready cycle", ready_at, 20);
      check("abort seq cmd_done pulses", cd_cnt, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
